// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - data-memory request/response bundle between memory stage and responder
interface dmem_responder_if;
  logic        memreq;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        stall;
  logic        done;
  logic [31:0] readdata;
  logic        err;

  modport master (
    output memreq, memwrite, addr, writedata,
    input  stall, done, readdata, err
  );

  modport slave (
    input  memreq, memwrite, addr, writedata,
    output stall, done, readdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency word-array responder for the pipeline data-memory port
// Optional misaligned-access flagging is compiled in with MISALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] req_idx;
  logic          req_write;
  logic [31:0]   req_data;
  logic          req_mis;
  logic [31:0]   readdata_q;
  logic          done_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          in_mis;
  logic          capture;
  logic          commit;
  logic [IW-1:0] c_idx;
  logic          c_write;
  logic [31:0]   c_data;
  logic          c_mis;
  logic          mem_we;
  logic          unused_addr;

`ifdef MISALIGN_CHECK_EN
  assign in_mis = |bus.addr[1:0];
`else
  assign in_mis = 1'b0;
`endif

  assign unused_addr = ^{bus.addr[31:IW+2], bus.addr[1:0]};

  // With LATENCY==1 the capture edge is also the commit edge, so the
  // commit path must see the live request rather than the latched copy.
  assign capture = (state == IDLE) && bus.memreq;
  assign commit  = (capture && (LATENCY == 1)) || ((state == WAIT) && (cnt == '0));
  assign c_idx   = capture ? bus.addr[IW+1:2] : req_idx;
  assign c_write = capture ? bus.memwrite     : req_write;
  assign c_data  = capture ? bus.writedata    : req_data;
  assign c_mis   = capture ? in_mis           : req_mis;
  assign mem_we  = reset && commit && c_write && !c_mis;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[c_idx] <= c_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_idx    <= '0;
      req_write  <= 1'b0;
      req_data   <= '0;
      req_mis    <= 1'b0;
      readdata_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= commit;
      err_q  <= commit && c_mis;
      if (commit) begin
        if (c_mis) begin
          readdata_q <= '0;
        end else if (c_write) begin
          readdata_q <= c_data;
        end else begin
          readdata_q <= mem[c_idx];
        end
      end

      case (state)
        IDLE: begin
          if (bus.memreq) begin
            req_idx   <= bus.addr[IW+1:2];
            req_write <= bus.memwrite;
            req_data  <= bus.writedata;
            req_mis   <= in_mis;
            if (LATENCY == 1) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= CW'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall    = capture || (state == WAIT);
  assign bus.done     = done_q;
  assign bus.readdata = readdata_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at LATENCY 2 and 1
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

`ifdef MISALIGN_CHECK_EN
  localparam logic MIS = 1'b1;
`else
  localparam logic MIS = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_responder_if b2 ();
  dmem_responder_if b1 ();

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(b2));
  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(b1));

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full LATENCY=2 access with memreq held until the done cycle; ends in IDLE.
  task automatic do_l2(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic dn, output logic [31:0] rd, output logic er);
    b2.memreq = 1'b1; b2.memwrite = w; b2.addr = a; b2.writedata = d;
    tick();
    tick();
    dn = b2.done; rd = b2.readdata; er = b2.err;
    b2.memreq = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    b2.memreq = 0; b2.memwrite = 0; b2.addr = 0; b2.writedata = 0;
    b1.memreq = 0; b1.memwrite = 0; b1.addr = 0; b1.writedata = 0;
    reset = 1'b0;
    repeat (3) tick();
    total++; if (b2.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", b2.done); end
    total++; if (b2.readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata: got %h want 0", b2.readdata); end
    total++; if (b2.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", b2.err); end
    total++; if (b2.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", b2.stall); end
    total++; if (b1.readdata !== 32'h0) begin bad++; $display("FAIL reset_l1_readdata: got %h want 0", b1.readdata); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    b2.memreq = 1; b2.memwrite = 1; b2.addr = 32'h10; b2.writedata = 32'hDEADBEEF;
    #1;
    total++; if (b2.stall !== 1'b1) begin bad++; $display("FAIL basic_stall_c0: got %b want 1", b2.stall); end
    tick();
    total++; if ({b2.stall, b2.done} !== 2'b10) begin bad++; $display("FAIL basic_wait: got stall,done=%b want 10", {b2.stall, b2.done}); end
    tick();
    total++; if ({b2.stall, b2.done} !== 2'b01) begin bad++; $display("FAIL basic_done: got stall,done=%b want 01", {b2.stall, b2.done}); end
    total++; if (b2.readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_wr_readdata: got %h want deadbeef", b2.readdata); end
    b2.memreq = 0;
    tick();
    total++; if (b2.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", b2.done); end
    b2.memreq = 1; b2.memwrite = 0; b2.addr = 32'h10; b2.writedata = 32'h0;
    tick();
    tick();
    total++; if (b2.done !== 1'b1) begin bad++; $display("FAIL basic_ld_done: got %b want 1", b2.done); end
    total++; if (b2.readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_ld_readdata: got %h want deadbeef", b2.readdata); end
    b2.memreq = 0;
    tick();
    total++; if (b2.readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_hold: got %h want deadbeef", b2.readdata); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] dpat, spat;
    b2.memreq = 1; b2.memwrite = 0; b2.addr = 32'h10;
    for (int i = 0; i < 9; i++) begin
      #1;
      dpat[i] = b2.done;
      spat[i] = b2.stall;
      tick();
    end
    b2.memreq = 0;
    tick();
    total++; if (dpat !== 9'b100100100) begin bad++; $display("FAIL b2b_done_pattern: got %b want 100100100", dpat); end
    total++; if (spat !== 9'b011011011) begin bad++; $display("FAIL b2b_stall_pattern: got %b want 011011011", spat); end
  endtask

  task automatic test_latency1();
    logic        w  [8] = '{1, 0, 1, 0, 1, 0, 0, 1};
    logic [31:0] a  [8] = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h40, 32'h40, 32'h44, 32'h48};
    logic [31:0] d  [8] = '{32'h0BADF00D, 0, 32'h13579BDF, 0, 32'h2468ACE0, 0, 0, 32'hFFFF0000};
    logic [31:0] model [64];
    logic [31:0] exp_rd;
    b1.memreq = 1;
    for (int i = 0; i < 8; i++) begin
      b1.memwrite = w[i]; b1.addr = a[i]; b1.writedata = d[i];
      #1;
      total++; if ({b1.stall, b1.done} !== 2'b10) begin bad++; $display("FAIL l1_idle_%0d: got stall,done=%b want 10", i, {b1.stall, b1.done}); end
      if (w[i]) begin
        model[a[i][7:2]] = d[i];
        exp_rd = d[i];
      end else begin
        exp_rd = model[a[i][7:2]];
      end
      tick();
      total++; if ({b1.stall, b1.done} !== 2'b01) begin bad++; $display("FAIL l1_done_%0d: got stall,done=%b want 01", i, {b1.stall, b1.done}); end
      total++; if (b1.readdata !== exp_rd) begin bad++; $display("FAIL l1_data_%0d: got %h want %h", i, b1.readdata, exp_rd); end
      tick();
    end
    b1.memreq = 0;
    tick();
  endtask

  task automatic test_drop();
    logic dn, er;
    logic [31:0] rd;
    b2.memreq = 1; b2.memwrite = 1; b2.addr = 32'h30; b2.writedata = 32'h55AA33CC;
    tick();
    b2.memreq = 0;
    #1;
    total++; if (b2.stall !== 1'b1) begin bad++; $display("FAIL drop_stall: got %b want 1", b2.stall); end
    tick();
    total++; if (b2.done !== 1'b1) begin bad++; $display("FAIL drop_done: got %b want 1", b2.done); end
    tick();
    do_l2(0, 32'h30, 0, dn, rd, er);
    total++; if (rd !== 32'h55AA33CC || dn !== 1'b1) begin bad++; $display("FAIL drop_load: got %h done %b want 55aa33cc done 1", rd, dn); end
  endtask

  task automatic test_reset_mid();
    logic dn, er;
    logic [31:0] rd;
    do_l2(1, 32'h20, 32'hAAAA5555, dn, rd, er);
    total++; if (rd !== 32'hAAAA5555) begin bad++; $display("FAIL rm_prior: got %h want aaaa5555", rd); end
    b2.memreq = 1; b2.memwrite = 1; b2.addr = 32'h20; b2.writedata = 32'h12345678;
    tick();
    reset = 1'b0;
    b2.memreq = 0;
    #1;
    total++; if ({b2.stall, b2.done, b2.err} !== 3'b000) begin bad++; $display("FAIL rm_outputs: got stall,done,err=%b want 000", {b2.stall, b2.done, b2.err}); end
    total++; if (b2.readdata !== 32'h0) begin bad++; $display("FAIL rm_readdata: got %h want 0", b2.readdata); end
    tick();
    tick();
    total++; if (b2.done !== 1'b0) begin bad++; $display("FAIL rm_no_done: got %b want 0", b2.done); end
    reset = 1'b1;
    tick();
    do_l2(0, 32'h20, 0, dn, rd, er);
    total++; if (rd !== 32'hAAAA5555) begin bad++; $display("FAIL rm_not_written: got %h want aaaa5555", rd); end
  endtask

  task automatic test_wrap();
    logic dn, er;
    logic [31:0] rd;
    do_l2(1, 32'h104, 32'hCAFEF00D, dn, rd, er);
    do_l2(0, 32'h004, 0, dn, rd, er);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap: got %h want cafef00d", rd); end
  endtask

  task automatic test_misalign();
    logic dn, er;
    logic [31:0] rd, exp_rd, exp_word;
    do_l2(1, 32'h20, 32'h77777777, dn, rd, er);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL mis_aligned_err: got %b want 0", er); end
    do_l2(1, 32'h22, 32'h11111111, dn, rd, er);
    exp_rd   = MIS ? 32'h0 : 32'h11111111;
    exp_word = MIS ? 32'h77777777 : 32'h11111111;
    total++; if (er !== MIS || dn !== 1'b1) begin bad++; $display("FAIL mis_err: got err %b done %b want err %b done 1", er, dn, MIS); end
    total++; if (rd !== exp_rd) begin bad++; $display("FAIL mis_readdata: got %h want %h", rd, exp_rd); end
    total++; if (b2.err !== 1'b0) begin bad++; $display("FAIL mis_err_clear: got %b want 0", b2.err); end
    do_l2(0, 32'h20, 0, dn, rd, er);
    total++; if (rd !== exp_word) begin bad++; $display("FAIL mis_word: got %h want %h", rd, exp_word); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_latency1();
    test_drop();
    test_reset_mid();
    test_wrap();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the pipelined core's data-memory port. It accepts the load/store request the memory stage presents (address, write enable, write data) and serves it from an internal word array after a fixed, parameterised latency. While the access is outstanding it drives a stall back to the pipeline. It is the slave end of the memwrite/aluout/writedata interface that the execute_memory register drives.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words in the array; power of two, minimum 2.
LATENCY, 2, cycles from the request-capture cycle to the done cycle; minimum 1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
memreq  input  1  memory stage holds a valid load or store.
memwrite  input  1  1 = store, 0 = load; sampled with memreq.
addr  input  32  byte address (aluoutM).
writedata  input  32  store data (writedataM).
stall  output  1  combinational; holds the pipeline while the access is outstanding.
done  output  1  one-cycle pulse; the access completes this cycle.
readdata  output  32  registered load data; valid while done=1, then held.
err  output  1  misaligned-access flag (see Optional Feature); 0 when the feature is compiled out.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, done=0, readdata=0, err=0, internal counter=0, latched request cleared. Array contents are not reset.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4. addr[1:0] is ignored unless MISALIGN_CHECK_EN is defined.
- FSM states: IDLE, WAIT, DONE.
- IDLE: if memreq=1 at the edge, latch addr, memwrite and writedata.
  - If LATENCY==1, go to DONE.
  - Otherwise go to WAIT with counter=LATENCY-2.
  - If memreq=0, stay in IDLE.
- WAIT: if counter==0, go to DONE; otherwise decrement the counter. Inputs are ignored; a memreq drop does not cancel a captured access.
- On the edge entering DONE:
  - Store: write writedata into the array at the latched index. readdata takes the new word (write-through read).
  - Load: readdata takes array[index].
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE. A memreq present in DONE is not captured; it is captured in the following IDLE cycle.
- Latency: a request captured at the end of cycle k gives done=1 in cycle k+LATENCY.
- stall = (state==IDLE & memreq) | (state==WAIT). stall=0 in DONE, which releases the pipeline on the done edge.
- Back-to-back requests: the next request is captured in the IDLE cycle after DONE. Consecutive accesses therefore complete every LATENCY+1 cycles.
- Reset mid-operation: the access is aborted. A store not yet committed (reset before the DONE entry edge) does not modify the array. No done pulse is produced.
- readdata holds its last value outside DONE. err is meaningful only while done=1 and is 0 otherwise.

Optional Feature:
MISALIGN_CHECK_EN.
- Defined: a captured access with addr[1:0]!=0 still runs the full latency. In its DONE cycle, err=1 and readdata=0, and a store does not modify the array.
- Undefined: addr[1:0] is ignored, err is tied to 0, and misaligned accesses behave as aligned accesses to the same word.

Test Plan:
- LATENCY=2: store 0xDEADBEEF to addr 0x10 captured in cycle 3 -> stall=1 in cycles 3-4, done=1 and stall=0 in cycle 5. A load of 0x10 captured in cycle 6 -> done in cycle 8 with readdata=0xDEADBEEF.
- LATENCY=1: alternating load/store stream -> done every 2nd cycle, stall never high in a DONE cycle, data matches a reference model.
- Store captured, memreq dropped in the WAIT cycle -> the write still commits, done still pulses, and a later load returns the stored data.
- Reset asserted in WAIT during a store of 0x12345678 to addr 0x20 (prior value 0xAAAA5555) -> outputs 0 immediately, no done, and a post-reset load of 0x20 returns 0xAAAA5555.
- DEPTH_WORDS=64: store 0xCAFEF00D to addr 0x104 -> a load of addr 0x004 returns 0xCAFEF00D (wrap-around).
- MISALIGN_CHECK_EN defined: store 0x11111111 to addr 0x22 -> err=1 and readdata=0 on done, and a load of 0x20 returns the old value. Macro undefined: the same store writes word 0x20 and err=0.
